// File: rtl/exception_mult_pipe.sv
// Purpose: pipelined FP multiplier exception stage: classifies operands, builds the special result and flags, accumulates sticky status.
// Latency: 2 cycles, from input handshake to out_valid; full throughput of 1 result/cycle while out_ready is held high.
// Backpressure: valid/ready; stalls ripple back combinationally to in_ready; outputs hold while out_valid & !out_ready.
//
// Ports:
//   clk, rst (sync, active-low)   | in_valid/in_ready, a, b, z_calc, overflow, underflow, inexact, rnd
//   out_valid/out_ready, z, zero_f/inf_f/nan_f/tiny_f/huge_f/inexact_f | sticky_clr, sticky {nan,inf,zero,tiny,huge,inexact}

package exception_mult_pipe_pkg;
    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_t;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;
endpackage

module exception_mult_pipe
    import exception_mult_pipe_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] z_calc,
    input  logic         overflow,
    input  logic         underflow,
    input  logic         inexact,
    input  round_t       rnd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic         zero_f,
    output logic         inf_f,
    output logic         nan_f,
    output logic         tiny_f,
    output logic         huge_f,
    output logic         inexact_f,
    input  logic         sticky_clr,
    output logic [5:0]   sticky
);

    // Flag vector bit positions, matching the sticky layout.
    localparam int F_NAN  = 5;
    localparam int F_INF  = 4;
    localparam int F_ZERO = 3;
    localparam int F_TINY = 2;
    localparam int F_HUGE = 1;
    localparam int F_INX  = 0;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Subnormals are flushed, so any zero exponent classifies as ZERO.
    function automatic cls_t classify(input logic [W-1:0] v);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = v[W-2:FRAC_W];
        f = v[FRAC_W-1:0];
        if (e == '0)
            return CLS_ZERO;
        else if (&e)
            return (f == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

    logic adv1, adv2;

    // Stage 1 state
    logic         s1_valid;
    logic         s1_sgn;
    logic [W-1:0] s1_zc;
    logic         s1_ovf, s1_unf, s1_inx;
    round_t       s1_rnd;
    cls_t         s1_cls_a, s1_cls_b;

    // Stage 2 state
    logic [5:0]   flags;

    // Stage 1 -> stage 2 combinational result
    logic [W-1:0] res_z;
    logic [5:0]   res_flags;
    logic         s_calc, toward_inf, away;
    logic         any_nan, any_inf, any_zero;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk) begin
        if (!rst)
            s1_valid <= 1'b0;
        else if (adv1)
            s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_sgn   <= a[W-1] ^ b[W-1];
            s1_zc    <= z_calc;
            s1_ovf   <= overflow;
            s1_unf   <= underflow;
            s1_inx   <= inexact;
            s1_rnd   <= rnd;
            s1_cls_a <= classify(a);
            s1_cls_b <= classify(b);
        end
    end

    always_comb begin
        res_z     = s1_zc;
        res_flags = '0;
        s_calc    = s1_zc[W-1];
        any_nan   = (s1_cls_a == CLS_NAN)  || (s1_cls_b == CLS_NAN);
        any_inf   = (s1_cls_a == CLS_INF)  || (s1_cls_b == CLS_INF);
        any_zero  = (s1_cls_a == CLS_ZERO) || (s1_cls_b == CLS_ZERO);
        // Directed rounding: overflow goes to infinity / underflow to min-norm
        // only when the rounding direction points away from zero for this sign.
        toward_inf = (s1_rnd == IEEE_near) || (s1_rnd == near_up) || (s1_rnd == away_zero) ||
                     ((s1_rnd == IEEE_pinf) && !s_calc) || ((s1_rnd == IEEE_ninf) && s_calc);
        away       = (s1_rnd == away_zero) ||
                     ((s1_rnd == IEEE_pinf) && !s_calc) || ((s1_rnd == IEEE_ninf) && s_calc);

        if (any_nan || (any_inf && any_zero)) begin
            res_z            = QNAN;
            res_flags[F_NAN] = 1'b1;
        end else if (any_inf) begin
            res_z            = {s1_sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            res_flags[F_INF] = 1'b1;
        end else if (any_zero) begin
            res_z             = {s1_sgn, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
            res_flags[F_ZERO] = 1'b1;
        end else if (s1_ovf) begin
            res_flags[F_HUGE] = 1'b1;
            res_flags[F_INX]  = 1'b1;
            if (toward_inf) begin
                res_z            = {s_calc, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                res_flags[F_INF] = 1'b1;
            end else begin
                res_z = {s_calc, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
            end
        end else if (s1_unf) begin
            res_flags[F_TINY] = 1'b1;
            res_flags[F_INX]  = 1'b1;
            if (away) begin
                res_z = {s_calc, {(EXP_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
            end else begin
                res_z             = {s_calc, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
                res_flags[F_ZERO] = 1'b1;
            end
        end else begin
            res_flags[F_INX]  = s1_inx;
            res_flags[F_ZERO] = (s1_zc[W-2:FRAC_W] == '0);
            res_flags[F_INF]  = &s1_zc[W-2:FRAC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            z         <= '0;
            flags     <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                z     <= res_z;
                flags <= res_flags;
            end
        end
    end

    // A clear coincident with a handshake still keeps that result's flags.
    always_ff @(posedge clk) begin
        if (!rst)
            sticky <= '0;
        else
            sticky <= (sticky_clr ? 6'b0 : sticky) | ((out_valid && out_ready) ? flags : 6'b0);
    end

    assign nan_f     = flags[F_NAN];
    assign inf_f     = flags[F_INF];
    assign zero_f    = flags[F_ZERO];
    assign tiny_f    = flags[F_TINY];
    assign huge_f    = flags[F_HUGE];
    assign inexact_f = flags[F_INX];

endmodule

// File: doc/exception_mult_pipe.md
Name: exception_mult_pipe

Overview:
- Parametrised, pipelined successor to the combinational multiplier exception stage.
- Sits between the multiplier's normalise/round stage and the FPU result bus.
- Classifies operands, including NaN, which the previous generation did not detect.
- Produces the IEEE-style special result and the per-operation flags, using direction-aware overflow/underflow per rounding mode.
- Carries valid/ready backpressure and accumulates sticky status flags for the control unit.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.
- W = 1+EXP_W+FRAC_W; derived localparam, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operand/result bundle valid.
- in_ready  out  1  block accepts bundle this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- z_calc  in  W  rounded product from the datapath.
- overflow  in  1  datapath exponent overflow.
- underflow  in  1  datapath exponent underflow.
- inexact  in  1  datapath rounding inexact.
- rnd  in  round_t  rounding mode (IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  W  final result.
- zero_f  out  1  zero flag for the current result.
- inf_f  out  1  infinity flag for the current result.
- nan_f  out  1  NaN flag for the current result.
- tiny_f  out  1  tiny flag for the current result.
- huge_f  out  1  huge flag for the current result.
- inexact_f  out  1  inexact flag for the current result.
- sticky_clr  in  1  clear sticky flags.
- sticky  out  6  accumulated {nan,inf,zero,tiny,huge,inexact}.

Behaviour:
- Pipeline: two register stages. S1 captures the inputs plus the operand classes. S2 captures z and the flags.
- Latency: input handshake at cycle N gives out_valid at cycle N+2 if not stalled.
- Full throughput: 1 result per cycle with out_ready held high.
- Handshake:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational).
  - Input is accepted iff in_valid & in_ready.
  - While out_valid & !out_ready, z and all flags hold stable.
  - No bundle is dropped or duplicated.
- Classification, per operand, with e = exp field and f = fraction field:
  - ZERO: e==0. Subnormals are flushed.
  - INF: e all-ones & f==0.
  - NAN: e all-ones & f!=0.
  - NORM: otherwise.
- Sign: s = a.sign ^ b.sign for special classes; s = z_calc sign for the NORM×NORM path.
- Result priority, highest first:
  1. Either operand NAN, or ZERO×INF: z = canonical qNaN {0, all-ones, 1 followed by FRAC_W-1 zeros}; nan_f=1; all other flags 0.
  2. INF×(INF|NORM): z = {s, all-ones, 0}; inf_f=1.
  3. ZERO×(ZERO|NORM): z = {s, 0, 0}; zero_f=1.
  4. NORM×NORM with overflow (overflow wins if both overflow and underflow are set):
     - huge_f=1, inexact_f=1.
     - toward_inf = rnd∈{IEEE_near, near_up, away_zero} | (rnd==IEEE_pinf & !s) | (rnd==IEEE_ninf & s).
     - toward_inf: z = {s, all-ones, 0}, inf_f=1.
     - else: z = max-norm {s, all-ones-1, all-ones}.
  5. NORM×NORM with underflow:
     - tiny_f=1, inexact_f=1.
     - away = rnd==away_zero | (rnd==IEEE_pinf & !s) | (rnd==IEEE_ninf & s).
     - away: z = min-norm {s, 1, 0}.
     - else: z = {s, 0, 0}, zero_f=1.
  6. Otherwise: z = z_calc; inexact_f = inexact; zero_f = (z_calc exp==0); inf_f = (z_calc exp all-ones).
- In cases 1–3, inexact_f=0 and the datapath flags are ignored.
- Sticky update: sticky <= (sticky_clr ? 0 : sticky) | (out_valid & out_ready ? flags : 0).
  - A clear coincident with a handshake keeps that result's flags.
  - Sticky bits update only on output handshake, never on stalled cycles.
- Reset (rst==0 at a clk edge):
  - s1_valid, out_valid, z, all flags and sticky go to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - In-flight bundles are discarded. No output handshake occurs during reset.
- The two pipeline registers are the only storage; there is no skid buffer.

Test Plan:
- 1.0×2.0 (a=0x3F800000, b=0x40000000, z_calc=0x40000000, flags 0), out_ready=1 -> z=0x40000000 at N+2; all flags 0; sticky=0.
- a=0x00000000, b=0xFF800000 -> z=0x7FC00000, nan_f=1. a=0x7FC00001, b=0x3F800000 -> z=0x7FC00000, nan_f=1; sticky[5]=1 after the handshake.
- NORM×NORM overflow with z_calc sign=1:
  - rnd=IEEE_pinf -> z=0xFF7FFFFF, huge_f=1, inexact_f=1, inf_f=0.
  - rnd=IEEE_ninf -> z=0xFF800000, inf_f=1.
  - rnd=IEEE_zero -> z=0xFF7FFFFF.
- NORM×NORM underflow with sign=0:
  - rnd=IEEE_pinf -> z=0x00800000, tiny_f=1.
  - rnd=IEEE_near -> z=0x00000000, zero_f=1, tiny_f=1.
- Backpressure: stream 4 bundles with out_ready=0 for 3 cycles.
  - in_ready falls after 2 accepts.
  - z holds the first result while stalled.
  - After release, 4 results arrive in order, no loss.
  - sticky_clr pulsed with the 3rd handshake -> sticky equals the 3rd|4th flags only.
- Assert rst=0 with 2 bundles in flight -> next cycle out_valid=0, sticky=0. Post-reset, a new bundle emerges after exactly 2 cycles.
